// File: rtl/alu_if.sv
// Execute-stage ALU bus: operands, op select and registered result with valid strobes.
interface alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Op;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             out_valid;

  modport master (
    output in_valid, A, B, ALU_Op,
    input  Result, Zero, out_valid
  );

  modport slave (
    input  in_valid, A, B, ALU_Op,
    output Result, Zero, out_valid
  );
endinterface

// File: rtl/alu.sv
// Registered integer ALU: one-cycle latency, result/zero hold while no valid input arrives.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLT  = 4'b1001,
    OP_SLTU = 4'b1010
  } alu_op_e;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;

  assign shamt = bus.B[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.ALU_Op)
      OP_ADD:  alu_res = bus.A + bus.B;
      OP_SUB:  alu_res = bus.A - bus.B;
      OP_MUL:  alu_res = bus.A * bus.B;
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_SLL:  alu_res = bus.A << shamt;
      OP_SRL:  alu_res = bus.A >> shamt;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_SRA:  alu_res = $unsigned($signed(bus.A) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      default: alu_res = '0;
    endcase
  end

  // Result and Zero only update on accepted inputs; out_valid tracks in_valid every cycle.
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      result_d = alu_res;
      zero_d   = (alu_res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.Result    = result_q;
  assign bus.Zero      = zero_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors queued at issue, checked when out_valid appears.
module tb_alu;
  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_zero);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.ALU_Op   = op;
    e.res  = exp_res;
    e.zero = exp_zero;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = a;
    bus.B        = b;
    bus.ALU_Op   = op;
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid actual=1 required=0 result=0x%08h", bus.Result);
        end else begin
          e = sb.pop_front();
          check("result", bus.Result, e.res);
          check("zero", {31'b0, bus.Zero}, {31'b0, e.zero});
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.ALU_Op   = '0;
    #23;
    check("reset_result", bus.Result, 32'h0);
    check("reset_zero", {31'b0, bus.Zero}, 32'h1);
    check("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
    #4 rst_n = 1'b1;

    issue(4'b0000, 32'd10, 32'd5, 32'd15, 1'b0);
    idle(4'b0000, 32'd0, 32'd0);

    // back-to-back arithmetic
    issue(4'b0001, 32'd20, 32'd7, 32'd13, 1'b0);
    issue(4'b0010, 32'd6, 32'd7, 32'd42, 1'b0);
    issue(4'b0001, 32'd5, 32'd5, 32'd0, 1'b1);
    issue(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    issue(4'b0010, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0);

    // logic and reserved codes
    issue(4'b0011, 32'h0C, 32'h0A, 32'h08, 1'b0);
    issue(4'b0100, 32'h0C, 32'h0A, 32'h0E, 1'b0);
    issue(4'b0111, 32'h0C, 32'h0A, 32'h06, 1'b0);
    issue(4'b1111, 32'h0C, 32'h0A, 32'h00, 1'b1);
    issue(4'b1011, 32'h1234, 32'h5678, 32'h00, 1'b1);

    // shifts
    issue(4'b0101, 32'd1, 32'd4, 32'd16, 1'b0);
    issue(4'b0110, 32'd16, 32'd2, 32'd4, 1'b0);
    issue(4'b0110, 32'h8000_0000, 32'd31, 32'd1, 1'b0);
    issue(4'b1000, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    issue(4'b0101, 32'd1, 32'h24, 32'd16, 1'b0);
    issue(4'b1000, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
    issue(4'b0101, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0);
    issue(4'b1000, 32'h4000_0000, 32'd4, 32'h0400_0000, 1'b0);

    // compares
    issue(4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    issue(4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    issue(4'b1001, 32'd3, 32'd3, 32'd0, 1'b1);
    issue(4'b1010, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);

    // valid gating: outputs hold 42 while inputs churn with in_valid low
    issue(4'b0010, 32'd6, 32'd7, 32'd42, 1'b0);
    idle(4'b0001, 32'd9, 32'd9);
    check("hold1_out_valid", {31'b0, bus.out_valid}, 32'h1);
    idle(4'b0000, 32'd100, 32'd200);
    check("hold2_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("hold2_result", bus.Result, 32'd42);
    check("hold2_zero", {31'b0, bus.Zero}, 32'h0);
    @(negedge clk);
    check("hold3_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("hold3_result", bus.Result, 32'd42);

    // reset while a result is in flight: the captured result is discarded
    issue(4'b0000, 32'd7, 32'd8, 32'd15, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_result", bus.Result, 32'h0);
    check("midrst_zero", {31'b0, bus.Zero}, 32'h1);
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    issue(4'b0001, 32'd3, 32'd10, 32'hFFFF_FFF9, 1'b0);
    idle(4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu.md
# alu

Registered 32-bit integer arithmetic/logic unit for the RISC-V CPU execute stage. It takes two operands and a 4-bit operation code and returns the result one clock later, together with a zero flag and a valid strobe. It supports add, subtract, low-word multiply, bitwise logic, shifts and set-less-than compares.

## Interface
- WIDTH, 32: operand/result width; shift amount uses the low log2(WIDTH) bits of B (B[4:0] at 32)
- clk  input  1  rising-edge clock; the block has one clock
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  A/B/ALU_Op valid this cycle
- A  input  WIDTH  operand A (rs1)
- B  input  WIDTH  operand B (rs2 or immediate)
- ALU_Op  input  4  operation select
- Result  output  WIDTH  registered result
- Zero  output  1  registered, high when Result == 0
- out_valid  output  1  Result/Zero valid this cycle

## Operation
- ALU_Op encoding (Result, modulo 2^WIDTH):
  - 0000 ADD: A + B, carry discarded
  - 0001 SUB: A − B, borrow discarded (two's complement wrap)
  - 0010 MUL: low WIDTH bits of A × B; identical for signed and unsigned operands
  - 0011 AND: A & B
  - 0100 OR: A | B
  - 0101 SLL: A << B[4:0]
  - 0110 SRL: A >> B[4:0], logical, zero fill
  - 0111 XOR: A ^ B
  - 1000 SRA: A >>> B[4:0], arithmetic, sign fill from A[31]
  - 1001 SLT: 1 if signed A < signed B, else 0
  - 1010 SLTU: 1 if unsigned A < unsigned B, else 0
  - 1011–1111: reserved, Result = 0 (Zero = 1)
- Shifts ignore B[31:5]. Shift by 0 returns A unchanged. Shift by 31 is legal.
- Zero = (next Result == 0). It is computed from the same combinational value that is registered into Result.
- No exceptions or overflow flag. Overflow on ADD/SUB/MUL wraps silently.

## Timing
- Combinational datapath from A/B/ALU_Op feeds output registers.
- Latency is 1 cycle: inputs sampled at rising edge N while in_valid=1 produce Result/Zero with out_valid=1 after edge N.
- out_valid is a registered copy of in_valid. It is high for exactly one cycle per accepted input.
- When in_valid=0 at an edge:
  - out_valid goes 0.
  - Result and Zero hold their previous values.
- No backpressure: a new operation can be issued every cycle (throughput 1/cycle). Back-to-back operations produce back-to-back results in order.
- Reset (rst_n=0) is asynchronous. It does not wait for clk and immediately forces:
  - Result = 0
  - Zero = 1
  - out_valid = 0
- Reset mid-operation discards the in-flight result.
- After rst_n deasserts, the first rising edge with in_valid=1 behaves normally.
- Inputs must be stable around the rising edge. Glitches between edges have no effect on outputs.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> Result=0, Zero=1, out_valid=0 immediately. Release, then drive in_valid=1, A=10, B=5, Op=0000 -> next cycle Result=15, Zero=0, out_valid=1.
- Arithmetic, back-to-back over three consecutive cycles:
  - SUB A=20, B=7 -> 13
  - MUL A=6, B=7 -> 42
  - SUB A=5, B=5 -> 0 with Zero=1
  - Each result appears one cycle after its input with out_valid continuously high.
  - Wrap check: ADD 0xFFFFFFFF + 1 -> 0, Zero=1.
- Logic with A=0x0C, B=0x0A:
  - AND -> 0x08
  - OR -> 0x0E
  - XOR -> 0x06
  - Op=1111 -> 0, Zero=1
- Shifts:
  - SLL A=1, B=4 -> 16
  - SRL A=16, B=2 -> 4
  - SRL A=0x80000000, B=31 -> 1
  - SRA A=0x80000000, B=4 -> 0xF8000000
  - SLL A=1, B=0x24 (only B[4:0]=4 used) -> 16
- Compares:
  - SLT A=0xFFFFFFFF (−1), B=1 -> 1
  - SLTU with the same operands -> 0
  - SLT A=3, B=3 -> 0, Zero=1
- Valid gating: after a result of 42, drop in_valid for 2 cycles while changing A/B/Op -> out_valid=0 and Result stays 42. Pulse rst_n low during an in-flight op -> result is lost, outputs return to reset values.
